// File: rtl/serial_subtractor.sv
// Digit-serial unsigned subtractor computing a - b - bin, DIGIT bits per clock,
// with a start/busy/done handshake. Define SERIAL_SUBTRACTOR_SAT_EN to clamp underflow results to zero.
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST_DIG = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, b_q, res_q;
    logic               borrow_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               bout_q, bout_d;
    logic               zero_q, zero_d;

    logic               load;
    logic               finish;
    logic [DIGIT:0]     dig_sub;
    logic [WIDTH+DIGIT-1:0] res_cat;
    logic [WIDTH-1:0]   res_shift;

    // One extra bit on the digit difference: its MSB is the borrow into the next digit.
    assign dig_sub   = {1'b0, a_q[DIGIT-1:0]} - {1'b0, b_q[DIGIT-1:0]} - {{DIGIT{1'b0}}, borrow_q};
    assign res_cat   = {dig_sub[DIGIT-1:0], res_q};
    assign res_shift = res_cat[WIDTH+DIGIT-1:DIGIT];

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt_q == LAST_DIG) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bout_d = dig_sub[DIGIT];
`ifdef SERIAL_SUBTRACTOR_SAT_EN
        diff_d = dig_sub[DIGIT] ? '0 : res_shift;
`else
        diff_d = res_shift;
`endif
        zero_d = (diff_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            zero_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            if (load) begin
                a_q      <= a;
                b_q      <= b;
                borrow_q <= bin;
                cnt_q    <= '0;
            end else if (state_q == RUN) begin
                a_q      <= a_q >> DIGIT;
                b_q      <= b_q >> DIGIT;
                res_q    <= res_shift;
                borrow_q <= dig_sub[DIGIT];
                cnt_q    <= cnt_q + CW'(1);
            end
            if (finish) begin
                diff_q <= diff_d;
                bout_q <= bout_d;
                zero_q <= zero_d;
            end
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign diff = diff_q;
    assign bout = bout_q;
    assign zero = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomised checks of serial_subtractor at WIDTH=8 for DIGIT = 1, 2, 4 and 8.
module tb_serial_subtractor;

`ifdef SERIAL_SUBTRACTOR_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] a, b;
    logic       bin;
    logic       start_r [4];
    logic       busy_w  [4];
    logic       done_w  [4];
    logic [7:0] diff_w  [4];
    logic       bout_w  [4];
    logic       zero_w  [4];

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_dut
            serial_subtractor #(.WIDTH(8), .DIGIT(1 << gi)) u_dut (
                .clk   (clk),
                .rst   (rst),
                .start (start_r[gi]),
                .a     (a),
                .b     (b),
                .bin   (bin),
                .busy  (busy_w[gi]),
                .done  (done_w[gi]),
                .diff  (diff_w[gi]),
                .bout  (bout_w[gi]),
                .zero  (zero_w[gi])
            );
        end
    endgenerate

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Starts an operation on DUT idx and checks the full handshake. A nonzero glitch
    // pulses start with unrelated operands during that RUN cycle.
    task automatic run_op(input int idx, input logic [7:0] av, input logic [7:0] bv,
                          input logic biv, input logic [7:0] exp_diff,
                          input logic exp_bout, input logic exp_zero, input int glitch);
        int n;
        n = 8 >> idx;
        @(negedge clk);
        a = av; b = bv; bin = biv;
        start_r[idx] = 1'b1;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start_r[idx] = 1'b0;
                a = ~av; b = ~bv; bin = ~biv;
            end
            if (c == glitch) begin
                start_r[idx] = 1'b1;
                a = 8'hFF; b = 8'h00; bin = 1'b0;
            end else if (c == glitch + 1) begin
                start_r[idx] = 1'b0;
            end
            check("busy_run", busy_w[idx], 1'b1);
            check("done_run", done_w[idx], 1'b0);
        end
        @(negedge clk);
        check("done_pulse", done_w[idx], 1'b1);
        check("busy_done", busy_w[idx], 1'b0);
        check("diff", diff_w[idx], exp_diff);
        check("bout", bout_w[idx], exp_bout);
        check("zero", zero_w[idx], exp_zero);
        $display("op digit=%0d a=%02h b=%02h bin=%0d -> diff=%02h bout=%0d zero=%0d (exp %02h %0d %0d)",
                 1 << idx, av, bv, biv, diff_w[idx], bout_w[idx], zero_w[idx],
                 exp_diff, exp_bout, exp_zero);
        @(negedge clk);
        check("done_width", done_w[idx], 1'b0);
    endtask

    initial begin
        logic [8:0] ref9;
        logic [7:0] av, bv, ed;
        logic       biv, eb;

        rst = 1'b1;
        a = '0; b = '0; bin = 1'b0;
        for (int i = 0; i < 4; i++) start_r[i] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check("rst_busy", busy_w[i], 1'b0);
            check("rst_done", done_w[i], 1'b0);
            check("rst_diff", diff_w[i], 8'h00);
            check("rst_bout", bout_w[i], 1'b0);
            check("rst_zero", zero_w[i], 1'b1);
        end
        rst = 1'b0;

        // Directed, DIGIT = 1
        run_op(0, 8'h5A, 8'h21, 1'b0, 8'h39, 1'b0, 1'b0, 0);
        run_op(0, 8'h10, 8'h20, 1'b0, SAT ? 8'h00 : 8'hF0, 1'b1, SAT, 0);
        run_op(0, 8'h00, 8'h00, 1'b1, SAT ? 8'h00 : 8'hFF, 1'b1, SAT, 0);
        run_op(0, 8'h77, 8'h77, 1'b0, 8'h00, 1'b0, 1'b1, 0);
        run_op(0, 8'h5A, 8'h21, 1'b0, 8'h39, 1'b0, 1'b0, 3);

        // Reset in cycle 5 of a new operation, with start also held high
        @(negedge clk);
        a = 8'h12; b = 8'h01; bin = 1'b0;
        start_r[0] = 1'b1;
        @(negedge clk);
        start_r[0] = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_busy", busy_w[0], 1'b1);
        rst = 1'b1;
        start_r[0] = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start_r[0] = 1'b0;
        check("abort_busy", busy_w[0], 1'b0);
        check("abort_diff", diff_w[0], 8'h00);
        check("abort_zero", zero_w[0], 1'b1);
        check("abort_bout", bout_w[0], 1'b0);
        for (int c = 0; c < 10; c++) begin
            check("abort_no_done", done_w[0], 1'b0);
            @(negedge clk);
        end
        run_op(0, 8'h5A, 8'h21, 1'b0, 8'h39, 1'b0, 1'b0, 0);

        // DIGIT = 4 back-to-back
        @(negedge clk);
        a = 8'hC3; b = 8'h4F; bin = 1'b0;
        start_r[2] = 1'b1;
        @(negedge clk);
        start_r[2] = 1'b0;
        check("b2b_busy1", busy_w[2], 1'b1);
        @(negedge clk);
        check("b2b_busy2", busy_w[2], 1'b1);
        @(negedge clk);
        check("b2b_done1", done_w[2], 1'b1);
        check("b2b_diff1", diff_w[2], 8'h74);
        check("b2b_bout1", bout_w[2], 1'b0);
        $display("op digit=4 a=c3 b=4f bin=0 -> diff=%02h bout=%0d (exp 74 0)", diff_w[2], bout_w[2]);
        a = 8'h01; b = 8'h02; bin = 1'b0;
        start_r[2] = 1'b1;
        @(negedge clk);
        start_r[2] = 1'b0;
        check("b2b_busy3", busy_w[2], 1'b1);
        check("b2b_done_gap", done_w[2], 1'b0);
        @(negedge clk);
        check("b2b_busy4", busy_w[2], 1'b1);
        check("b2b_hold_diff", diff_w[2], 8'h74);
        @(negedge clk);
        check("b2b_done2", done_w[2], 1'b1);
        check("b2b_diff2", diff_w[2], SAT ? 8'h00 : 8'hFF);
        check("b2b_bout2", bout_w[2], 1'b1);
        check("b2b_zero2", zero_w[2], SAT);
        $display("op digit=4 a=01 b=02 bin=0 -> diff=%02h bout=%0d", diff_w[2], bout_w[2]);
        @(negedge clk);
        check("b2b_done_width", done_w[2], 1'b0);

        // Randomised, 250 vectors per DIGIT setting
        for (int idx = 0; idx < 4; idx++) begin
            for (int v = 0; v < 250; v++) begin
                av   = 8'($urandom);
                bv   = 8'($urandom);
                biv  = 1'($urandom);
                ref9 = {1'b0, av} - {1'b0, bv} - {8'h00, biv};
                eb   = ref9[8];
                ed   = (SAT && eb) ? 8'h00 : ref9[7:0];
                run_op(idx, av, bv, biv, ed, eb, (ed == 8'h00), 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
